seq_divider_32_bit: RTL and testbench
=====================================

# seq_divider_32_bit

Multi-cycle 32-bit integer divider implementing the RISC-V M-extension DIV, DIVU, REM and REMU operations. It is the inverse arithmetic counterpart of the datapath adder: a restoring shift-subtract engine that produces one quotient bit per clock. It sits beside the ALU. The core stalls on `busy` and captures `result` on the `done` pulse.

## Interface
Parameters:
- none (width fixed at 32; iteration count fixed at 32)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU
- `a`  in  32  dividend; sampled with `start`
- `b`  in  32  divisor; sampled with `start`
- `busy`  out  1  high while an operation is in progress
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle
- `result`  out  32  quotient or remainder selected by `op`; held until the next accepted `start`

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE with `start`=1:
  - latch `op`.
  - Signed ops: latch |a| and |b| and record the sign of `a` and the sign of `b`.
  - Unsigned ops: latch `a` and `b` raw.
  - Clear the 33-bit partial remainder and the 5-bit counter.
  - Go to CALC, or go directly to DONE on a special case.
- Special cases are decided at accept and skip CALC/FIX:
  - b==0, DIV/DIVU: result = 0xFFFFFFFF.
  - b==0, REM/REMU: result = a.
  - DIV with a==0x80000000 and b==0xFFFFFFFF: result = 0x80000000.
  - REM with a==0x80000000 and b==0xFFFFFFFF: result = 0.
- CALC, each cycle:
  - rem' = {rem[31:0], dividend[31]}.
  - diff = rem' − divisor, computed as a 33-bit subtraction (invert divisor, carry-in 1).
  - If diff is non-negative: rem = diff and the quotient bit is 1. Otherwise rem = rem' and the quotient bit is 0.
  - Shift the dividend left, inserting the quotient bit at the LSB.
  - Counter increments. Leave CALC after counter==31 (32 iterations).
- FIX, one cycle:
  - Signed quotient is negated (two's complement) if sign(a) XOR sign(b).
  - Signed remainder is negated if sign(a).
  - Select quotient or remainder per `op` and load `result`.
  - Go to DONE.
- DONE, one cycle: `done`=1, `busy`=0, then return to IDLE.
- `start` outside IDLE is ignored and no operands are resampled. This includes `start` in the DONE cycle.
- Reset (any state, including mid-CALC) takes effect at the next edge and sets:
  - state = IDLE
  - busy = 0
  - done = 0
  - result = 0x00000000
  - internal registers cleared
  - the in-flight operation is discarded with no `done` pulse.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0.
- Cycle 0 is the cycle in which `start`=1 is sampled in IDLE.
- Normal operation:
  - `busy`=1 in cycles 1–33 (CALC 1–32, FIX 33).
  - `done`=1 and `result` valid in cycle 34; `busy`=0 in cycle 34.
  - Latency is 34 cycles.
- Special case: `done`=1 in cycle 1, `busy` never asserts; latency is 1 cycle.
- Earliest next accept: cycle 35 (normal) or cycle 2 (special). DONE always returns to IDLE for one cycle first.
- `result` changes only at the FIX→DONE edge, at a special-case accept edge, or at reset. It is stable otherwise.
- `busy` and `done` are registered outputs with no combinational path from inputs.

## Test plan
- DIV a=100, b=7 -> `done` in cycle 34, result=14. REM with the same operands -> result=2.
- DIV a=−100 (0xFFFFFF9C), b=7 -> result=0xFFFFFFF2 (−14). REM with the same operands -> result=0xFFFFFFFE (−2). REMU a=0xFFFFFFFF, b=2 -> result=1. DIVU with the same operands -> 0x7FFFFFFF.
- Divide by zero: DIVU a=5, b=0 -> `done` in cycle 1, result=0xFFFFFFFF, `busy` never high. REM a=5, b=0 -> result=5.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000 in cycle 1. REM with the same operands -> result=0.
- `start` re-asserted with new operands in cycle 10 and again in the DONE cycle -> both ignored; the first operation's result is unchanged. A later `start` from IDLE is accepted normally.
- `rst`=1 in cycle 15 of an operation -> cycle 16 shows `busy`=0, `done`=0, result=0. No `done` pulse follows. A new DIVU a=1000, b=10 then yields 100 in cycle 34 after its own start.

Source files
------------

// File: rtl/seq_divider_32_bit.sv
// ---------------------------------------------------------------------------
// seq_divider_32_bit
//
// Multi-cycle 32-bit integer divider for the RISC-V M-extension DIV, DIVU,
// REM and REMU operations. A restoring shift-subtract engine retires one
// quotient bit per clock. The core stalls while busy is high and captures
// result on the one-cycle done pulse.
//
// Ports:
//   clk     in   1   rising-edge clock
//   rst     in   1   synchronous, active-high reset
//   start   in   1   request, only honoured while idle
//   op      in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a       in  32   dividend, sampled with start
//   b       in  32   divisor, sampled with start
//   busy    out  1   high while an operation is being computed
//   done    out  1   one-cycle pulse, result valid in that cycle
//   result  out 32   quotient or remainder, held until the next accept
//
// Flow: IDLE -> CALC (32 cycles) -> FIX (1 cycle) -> DONE (1 cycle) -> IDLE.
// Divide-by-zero and signed overflow are resolved at accept and jump
// straight from IDLE to DONE.
// ---------------------------------------------------------------------------
module seq_divider_32_bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [1:0]  r_op;
  logic        r_signA;
  logic        r_signB;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic [31:0] r_rem;
  logic [4:0]  r_count;
  logic [31:0] r_result;
  logic        r_busy;
  logic        r_done;

  logic        w_signedIn;
  logic        w_divByZero;
  logic        w_overflow;
  logic        w_special;
  logic [31:0] w_specialResult;
  logic [31:0] w_absA;
  logic [31:0] w_absB;

  logic        w_signedOp;
  logic [32:0] w_remShift;
  logic [32:0] w_diff;
  logic        w_qBit;
  logic [31:0] w_quotFix;
  logic [31:0] w_remFix;
  logic [31:0] w_fixResult;

  // Accept-time decode on the raw inputs: op[0]==0 marks the signed
  // variants, and the two special cases are recognised here so they can
  // bypass the iterative engine entirely.
  always_comb begin
    w_signedIn  = ~op[0];
    w_divByZero = (b == 32'd0);
    w_overflow  = w_signedIn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    w_special   = w_divByZero | w_overflow;
    w_absA      = (w_signedIn && a[31]) ? (32'd0 - a) : a;
    w_absB      = (w_signedIn && b[31]) ? (32'd0 - b) : b;
  end

  // Special-case answers. A zero divisor returns all ones for a quotient
  // and the untouched dividend for a remainder; signed overflow returns
  // the most negative value for DIV and zero for REM.
  always_comb begin
    w_specialResult = 32'd0;
    if (w_divByZero) begin
      w_specialResult = op[1] ? a : 32'hFFFF_FFFF;
    end else begin
      w_specialResult = op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One restoring step. The partial remainder is always below the divisor,
  // so only 32 bits are stored; the shifted value needs 33 bits, and the
  // subtraction is done as add-inverse-plus-one so its top bit is the
  // borrow that decides the quotient bit.
  always_comb begin
    w_remShift = {r_rem, r_dividend[31]};
    w_diff     = w_remShift + ~{1'b0, r_divisor} + 33'd1;
    w_qBit     = ~w_diff[32];
  end

  // Sign correction applied once after the magnitudes are divided: the
  // quotient takes the XOR of the operand signs, the remainder follows
  // the dividend's sign.
  always_comb begin
    w_signedOp  = ~r_op[0];
    w_quotFix   = (w_signedOp && (r_signA ^ r_signB)) ? (32'd0 - r_dividend) : r_dividend;
    w_remFix    = (w_signedOp && r_signA) ? (32'd0 - r_rem) : r_rem;
    w_fixResult = r_op[1] ? w_remFix : w_quotFix;
  end

  // Next-state logic. start is only looked at in IDLE, so a request that
  // arrives during CALC, FIX or DONE has no effect at all.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = w_special ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_count == 5'd31) begin
          w_nextState = FIX;
        end
      end
      FIX:     w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // busy and done come straight from flops fed by the next state, so they
  // line up with the state they describe and have no path from inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_nextState == CALC) || (w_nextState == FIX);
      r_done <= (w_nextState == DONE);
    end
  end

  // Datapath. Operands are captured only on an accepted start; the
  // dividend register doubles as the quotient shift register, receiving
  // one quotient bit at its LSB per CALC cycle. result is written only at
  // FIX or at a special-case accept, and otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= 2'd0;
      r_signA    <= 1'b0;
      r_signB    <= 1'b0;
      r_dividend <= 32'd0;
      r_divisor  <= 32'd0;
      r_rem      <= 32'd0;
      r_count    <= 5'd0;
      r_result   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op       <= op;
            r_signA    <= w_signedIn & a[31];
            r_signB    <= w_signedIn & b[31];
            r_dividend <= w_absA;
            r_divisor  <= w_absB;
            r_rem      <= 32'd0;
            r_count    <= 5'd0;
            if (w_special) begin
              r_result <= w_specialResult;
            end
          end
        end
        CALC: begin
          r_rem      <= w_qBit ? w_diff[31:0] : w_remShift[31:0];
          r_dividend <= {r_dividend[30:0], w_qBit};
          r_count    <= r_count + 5'd1;
        end
        FIX: begin
          r_result <= w_fixResult;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_seq_divider_32_bit.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_32_bit
//
// Directed bench for seq_divider_32_bit. Each issued operation pushes its
// hand-computed result and latency into a queue; a monitor pops an entry
// whenever done pulses and compares result, latency and busy.
// ---------------------------------------------------------------------------
module tb_seq_divider_32_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    string       name;
    logic [31:0] expResult;
    int          expLatency;
    int          issueCycle;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycleCount = 0;

  seq_divider_32_bit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Free-running clock and a cycle counter that is read only on negedges.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycleCount <= cycleCount + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one request for a single cycle and record what should come back.
  // Operands are scrambled afterwards so any late resampling shows up.
  task automatic applyStimulus(input string name, input logic [1:0] opIn,
                               input logic [31:0] aIn, input logic [31:0] bIn,
                               input logic [31:0] expResult, input int expLatency);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = opIn;
    a     = aIn;
    b     = bIn;
    e.name       = name;
    e.expResult  = expResult;
    e.expLatency = expLatency;
    e.issueCycle = cycleCount;
    expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op    = 2'b01;
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_0003;
  endtask

  // Wait until every expected response has been seen, bounded in cycles.
  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL %s_timeout: got %0d pending responses after %0d cycles, expected 0",
               name, expQ.size(), n);
      expQ.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpectedDone: got done=1 at cycle %0d, expected no pulse",
                   cycleCount);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput({e.name, "_result"}, result, e.expResult);
          checkOutput({e.name, "_latency"}, 32'(cycleCount - e.issueCycle),
                      32'(e.expLatency));
          checkOutput({e.name, "_busyAtDone"}, {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy",   {31'd0, busy}, 32'd0);
    checkOutput("resetDone",   {31'd0, done}, 32'd0);
    checkOutput("resetResult", result, 32'd0);
    rst = 1'b0;

    // Normal DIV with busy window checks at cycles 1 and 33.
    applyStimulus("div100by7", OP_DIV, 32'd100, 32'd7, 32'd14, 34);
    checkOutput("busyCycle1", {31'd0, busy}, 32'd1);
    repeat (32) @(negedge clk);
    checkOutput("busyCycle33", {31'd0, busy}, 32'd1);
    checkOutput("doneCycle33", {31'd0, done}, 32'd0);
    waitDrain("div100by7");

    applyStimulus("rem100by7", OP_REM, 32'd100, 32'd7, 32'd2, 34);
    waitDrain("rem100by7");
    applyStimulus("divNeg100by7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34);
    waitDrain("divNeg100by7");
    applyStimulus("remNeg100by7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34);
    waitDrain("remNeg100by7");
    applyStimulus("div100byNeg7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
    waitDrain("div100byNeg7");
    applyStimulus("rem100byNeg7", OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 34);
    waitDrain("rem100byNeg7");
    applyStimulus("remuMaxBy2", OP_REMU, 32'hFFFF_FFFF, 32'd2, 32'd1, 34);
    waitDrain("remuMaxBy2");
    applyStimulus("divuMaxBy2", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34);
    waitDrain("divuMaxBy2");
    applyStimulus("remuMinByMax", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    waitDrain("remuMinByMax");

    // Special cases: answered in cycle 1, busy never rises.
    applyStimulus("divu5by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    checkOutput("divu5by0_busy", {31'd0, busy}, 32'd0);
    waitDrain("divu5by0");
    applyStimulus("rem5by0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
    checkOutput("rem5by0_busy", {31'd0, busy}, 32'd0);
    waitDrain("rem5by0");
    applyStimulus("divOverflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    checkOutput("divOverflow_busy", {31'd0, busy}, 32'd0);
    waitDrain("divOverflow");
    applyStimulus("remOverflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    checkOutput("remOverflow_busy", {31'd0, busy}, 32'd0);
    waitDrain("remOverflow");

    // start during CALC (cycle 10) and during DONE (cycle 34) is ignored.
    applyStimulus("divIgnoreStart", OP_DIV, 32'd100, 32'd7, 32'd14, 34);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd1000;
    b     = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (23) @(negedge clk);
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd5;
    b     = 32'd0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignoreDoneStart_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("ignoreStart_resultHeld", result, 32'd14);
    waitDrain("divIgnoreStart");

    applyStimulus("remAfterIgnore", OP_REM, 32'd100, 32'd7, 32'd2, 34);
    waitDrain("remAfterIgnore");

    // Reset in cycle 15 discards the operation without a done pulse.
    applyStimulus("divAborted", OP_DIV, 32'd100, 32'd7, 32'd14, 34);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    expQ.delete();
    @(negedge clk);
    checkOutput("abortBusy",   {31'd0, busy}, 32'd0);
    checkOutput("abortDone",   {31'd0, done}, 32'd0);
    checkOutput("abortResult", result, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    applyStimulus("divu1000by10", OP_DIVU, 32'd1000, 32'd10, 32'd100, 34);
    waitDrain("divu1000by10");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
